// File: rtl/muldiv_sched.sv
// Iterative MIPS mul/div unit owning HI/LO: 1 bit per cycle, ITERS+1 edges accept-to-commit.
// Issue is held off (req_ready low) whenever the datapath is not IDLE or a flush is pending.
module muldiv_sched #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            req_ready,
  output logic            stall,
  output logic            busy,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_zero
);
  localparam int CW = $clog2(ITERS);
  localparam logic [2:0] OP_MUL   = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MULT  = 3'd6;
  localparam logic [2:0] OP_MULTU = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r, dz_q;

  logic              accept, req_signed, a_neg, b_neg, is_mul_q;
  logic [XLEN-1:0]   a_mag, b_mag, diff, quo_fix, rem_fix;
  logic [XLEN:0]     sum, shl;
  logic [2*XLEN-1:0] acc_step, prod_fix;

  assign req_ready = (state == IDLE) && !flush;
  assign stall     = req_valid && !req_ready;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_signed = (req_op == OP_MUL) || (req_op == OP_MULT) || (req_op == OP_DIV);
    a_neg      = req_signed && req_a[XLEN-1];
    b_neg      = req_signed && req_b[XLEN-1];
    a_mag      = a_neg ? -req_a : req_a;
    b_mag      = b_neg ? -req_b : req_b;
  end

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
  always_comb begin
    is_mul_q = (op_q == OP_MUL) || (op_q == OP_MULT) || (op_q == OP_MULTU);
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
    shl      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = shl[XLEN-1:0] - opnd;
    if (is_mul_q)
      acc_step = {sum, acc[XLEN-1:1]};
    else if (shl >= {1'b0, opnd})
      acc_step = {diff, acc[XLEN-2:0], 1'b1};
    else
      acc_step = {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      opnd     <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      div_zero <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MFHI: begin
                wb_valid <= 1'b1;
                wb_rd    <= req_rd;
                wb_data  <= hi;
              end
              OP_MFLO: begin
                wb_valid <= 1'b1;
                wb_rd    <= req_rd;
                wb_data  <= lo;
              end
              OP_MUL, OP_MULT, OP_MULTU: begin
                op_q  <= req_op;
                rd_q  <= req_rd;
                opnd  <= a_mag;
                acc   <= {{XLEN{1'b0}}, b_mag};
                neg_q <= a_neg ^ b_neg;
                neg_r <= 1'b0;
                dz_q  <= 1'b0;
                cnt   <= '0;
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= req_op;
                rd_q  <= req_rd;
                opnd  <= b_mag;
                acc   <= {{XLEN{1'b0}}, a_mag};
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                dz_q  <= (req_b == '0);
                cnt   <= '0;
                state <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ITERS - 1))
              state <= FIXUP;
          end
        end
        FIXUP: begin
          state <= IDLE;
          if (!flush) begin
            if (op_q == OP_MUL) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= prod_fix[XLEN-1:0];
            end else if (is_mul_q) begin
              hi <= prod_fix[2*XLEN-1:XLEN];
              lo <= prod_fix[XLEN-1:0];
            end else begin
              // a zero divisor leaves the dividend in the remainder path after sign fixup
              lo       <= dz_q ? {XLEN{1'b1}} : quo_fix;
              hi       <= rem_fix;
              div_zero <= dz_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: hand-computed HI/LO, writeback, stall, flush and reset cases.
module tb_muldiv_sched;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        req_ready, stall, busy, wb_valid, div_zero;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOP = 3'd0, MUL = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MFHI = 3'd4, MFLO = 3'd5, MULT = 3'd6, MULTU = 3'd7;

  muldiv_sched #(.XLEN(32), .ITERS(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .req_ready(req_ready), .stall(stall), .busy(busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Called 1ns after an edge with the DUT idle; returns 1ns after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = NOP;
  endtask

  task automatic wait_done(output int n, output bit wb_seen);
    n = 0; wb_seen = 1'b0;
    while (busy && n < 60) begin
      n++;
      if (wb_valid) wb_seen = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 1'b0; req_op = NOP; req_a = '0; req_b = '0;
    req_rd = '0; flush = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d expected 0", wb_rd); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_multu;
    int n; bit wbs;
    issue(MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0);
    wait_done(n, wbs);
    checks++; if (n !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", n); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
    checks++; if ((wbs | wb_valid) !== 1'b0) begin errors++; $display("FAIL multu_no_wb: got %b expected 0", wbs | wb_valid); end
  endtask

  task automatic test_div_signed;
    int n; bit wbs;
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
    wait_done(n, wbs);
    checks++; if (n !== 33) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 33", n); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    issue(DIVU, 32'hFFFF_FFF9, 32'd2, 5'd0);
    wait_done(n, wbs);
    checks++; if (lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo: got %h expected 7ffffffc", lo); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL divu_hi: got %h expected 00000001", hi); end
    issue(MFHI, 32'h0, 32'h0, 5'd7);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mfhi_wb_valid: got %b expected 1", wb_valid); end
    checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL mfhi_wb_rd: got %0d expected 7", wb_rd); end
    checks++; if (wb_data !== 32'h0000_0001) begin errors++; $display("FAIL mfhi_wb_data: got %h expected 00000001", wb_data); end
  endtask

  task automatic test_div_zero;
    int n; bit wbs;
    issue(DIVU, 32'h0000_1234, 32'h0, 5'd0);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_early: got %b expected 0", div_zero); end
    wait_done(n, wbs);
    checks++; if (n !== 33) begin errors++; $display("FAIL dz_busy_cycles: got %0d expected 33", n); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL dz_hi: got %h expected 00001234", hi); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_pulse: got %b expected 1", div_zero); end
    @(posedge clk); #1;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_single: got %b expected 0", div_zero); end
  endtask

  task automatic test_overflow;
    int n; bit wbs;
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_done(n, wbs);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi: got %h expected 0", hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL ovf_no_flag: got %b expected 0", div_zero); end
  endtask

  task automatic test_mul;
    int n; bit wbs;
    issue(MUL, 32'hFFFF_FFFD, 32'd5, 5'd9);
    wait_done(n, wbs);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mul_wb_valid: got %b expected 1", wb_valid); end
    checks++; if (wb_rd !== 5'd9) begin errors++; $display("FAIL mul_wb_rd: got %0d expected 9", wb_rd); end
    checks++; if (wb_data !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_wb_data: got %h expected fffffff1", wb_data); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mul_hi_kept: got %h expected 0", hi); end
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL mul_lo_kept: got %h expected 80000000", lo); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mul_wb_pulse: got %b expected 0", wb_valid); end
    checks++; if (wb_data !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_wb_hold: got %h expected fffffff1", wb_data); end
  endtask

  task automatic test_mflo_stall;
    int n = 0;
    issue(MULT, 32'hFFFF_FFFE, 32'd3, 5'd0);
    req_valid = 1'b1; req_op = MFLO; req_rd = 5'd4;
    #1;
    while (stall && n < 60) begin
      n++;
      @(posedge clk); #2;
    end
    checks++; if (n !== 33) begin errors++; $display("FAIL mflo_stall_cycles: got %0d expected 33", n); end
    checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = NOP;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mflo_wb_valid: got %b expected 1", wb_valid); end
    checks++; if (wb_rd !== 5'd4) begin errors++; $display("FAIL mflo_wb_rd: got %0d expected 4", wb_rd); end
    checks++; if (wb_data !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mflo_wb_data: got %h expected fffffffa", wb_data); end
  endtask

  task automatic test_back_to_back;
    int n; bit wbs;
    issue(DIVU, 32'd100, 32'd7, 5'd0);
    repeat (32) @(posedge clk); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_fixup_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b expected 1", req_ready); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_lo1: got %h expected 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi1: got %h expected 00000002", hi); end
    issue(DIVU, 32'd1000, 32'd10, 5'd0);
    wait_done(n, wbs);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_cycles: got %0d expected 33", n); end
    checks++; if (lo !== 32'd100) begin errors++; $display("FAIL b2b_lo2: got %h expected 00000064", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL b2b_hi2: got %h expected 0", hi); end
  endtask

  task automatic test_flush;
    issue(DIV, 32'd100, 32'd7, 5'd0);
    repeat (10) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy %b expected 0", busy); end
    req_valid = 1'b1; req_op = MFHI; #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = NOP; flush = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_no_mfhi: got %b expected 0", wb_valid); end
    repeat (30) @(posedge clk); #1;
    checks++; if (lo !== 32'd100) begin errors++; $display("FAIL flush_lo_kept: got %h expected 00000064", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL flush_hi_kept: got %h expected 0", hi); end
  endtask

  task automatic test_reset_mid_op;
    issue(MULT, 32'd5, 32'd7, 5'd0);
    repeat (20) @(posedge clk); #1;
    reset_n = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h expected 0", lo); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_mid_wb_data: got %h expected 0", wb_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    issue(MFHI, 32'h0, 32'h0, 5'd3);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rst_mfhi_valid: got %b expected 1", wb_valid); end
    checks++; if (wb_rd !== 5'd3) begin errors++; $display("FAIL rst_mfhi_rd: got %0d expected 3", wb_rd); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_mfhi_data: got %h expected 0", wb_data); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_div_signed;
    test_div_zero;
    test_overflow;
    test_mul;
    test_mflo_stall;
    test_back_to_back;
    test_flush;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
